// File: rtl/kbd_ps2_matrix.sv
// PS/2 keyboard receiver and scan-code decoder driving a 64-key matrix image.
// Optional KBD_ERR_CLEAR_EN: a frame error also releases every key.
module kbd_ps2_matrix #(
  parameter int TIMEOUT = 2048
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [63:0] kbmat,
  output logic        key_evt,
  output logic        kb_err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} st_t;

  logic [1:0]    clk_sy, dat_sy;
  logic          clk_q, fall;
  st_t           st;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh, byte_q;
  logic          par, byte_vld;
  logic [TW-1:0] to_cnt;
  logic          ext, rel;
  logic [2:0]    skip;
  logic [6:0]    km;

  assign fall = clk_q & ~clk_sy[1];

  // Frame receiver: par accumulates XOR of data+parity, so 1 means odd parity
  always_ff @(posedge mck) begin
    if (!rin_n) begin
      clk_sy   <= 2'b11;
      dat_sy   <= 2'b11;
      clk_q    <= 1'b1;
      st       <= IDLE;
      bit_cnt  <= '0;
      sh       <= '0;
      par      <= 1'b0;
      to_cnt   <= '0;
      byte_vld <= 1'b0;
      byte_q   <= '0;
      kb_err   <= 1'b0;
    end else begin
      clk_sy   <= {clk_sy[0], ps2_clk};
      dat_sy   <= {dat_sy[0], ps2_dat};
      clk_q    <= clk_sy[1];
      byte_vld <= 1'b0;
      kb_err   <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (st)
          IDLE: if (!dat_sy[1]) begin
            st      <= DATA;
            bit_cnt <= '0;
            par     <= 1'b0;
          end
          DATA: begin
            sh      <= {dat_sy[1], sh[7:1]};
            par     <= par ^ dat_sy[1];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) st <= PARITY;
          end
          PARITY: begin
            par <= par ^ dat_sy[1];
            st  <= STOP;
          end
          STOP: begin
            st <= IDLE;
            if (dat_sy[1] && par) begin
              byte_vld <= 1'b1;
              byte_q   <= sh;
            end else begin
              kb_err <= 1'b1;
            end
          end
        endcase
      end else if (st != IDLE) begin
        if (to_cnt == TW'(TIMEOUT - 1)) begin
          st     <= IDLE;
          kb_err <= 1'b1;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // {ext, code} -> {hit, matrix index}
  function automatic logic [6:0] key_map(input logic [8:0] code);
    logic [6:0] k;
    k = '0;
    case (code)
      9'h01C: k = {1'b1, 6'd49};  9'h029: k = {1'b1, 6'd46};
      9'h05A: k = {1'b1, 6'd6};   9'h012: k = {1'b1, 6'd54};
      9'h059: k = {1'b1, 6'd63};  9'h175: k = {1'b1, 6'd35};
      9'h16B: k = {1'b1, 6'd33};  9'h076: k = {1'b1, 6'd61};
      9'h075: k = {1'b1, 6'd52};  9'h032: k = {1'b1, 6'd0};
      9'h021: k = {1'b1, 6'd1};   9'h023: k = {1'b1, 6'd2};
      9'h024: k = {1'b1, 6'd3};   9'h02B: k = {1'b1, 6'd4};
      9'h034: k = {1'b1, 6'd5};   9'h033: k = {1'b1, 6'd7};
      9'h043: k = {1'b1, 6'd8};   9'h03B: k = {1'b1, 6'd9};
      9'h042: k = {1'b1, 6'd10};  9'h04B: k = {1'b1, 6'd11};
      9'h03A: k = {1'b1, 6'd12};  9'h031: k = {1'b1, 6'd13};
      9'h044: k = {1'b1, 6'd14};  9'h04D: k = {1'b1, 6'd15};
      9'h015: k = {1'b1, 6'd16};  9'h02D: k = {1'b1, 6'd17};
      9'h01B: k = {1'b1, 6'd18};  9'h02C: k = {1'b1, 6'd19};
      9'h03C: k = {1'b1, 6'd20};  9'h02A: k = {1'b1, 6'd21};
      9'h01D: k = {1'b1, 6'd22};  9'h022: k = {1'b1, 6'd23};
      9'h035: k = {1'b1, 6'd24};  9'h01A: k = {1'b1, 6'd25};
      9'h016: k = {1'b1, 6'd26};  9'h01E: k = {1'b1, 6'd27};
      9'h026: k = {1'b1, 6'd28};  9'h025: k = {1'b1, 6'd29};
      9'h02E: k = {1'b1, 6'd30};  9'h036: k = {1'b1, 6'd31};
      9'h03D: k = {1'b1, 6'd32};  9'h03E: k = {1'b1, 6'd34};
      9'h046: k = {1'b1, 6'd36};  9'h045: k = {1'b1, 6'd37};
      9'h066: k = {1'b1, 6'd38};  9'h00D: k = {1'b1, 6'd39};
      9'h014: k = {1'b1, 6'd40};  9'h011: k = {1'b1, 6'd41};
      9'h058: k = {1'b1, 6'd42};  9'h04E: k = {1'b1, 6'd43};
      9'h055: k = {1'b1, 6'd44};  9'h054: k = {1'b1, 6'd45};
      9'h05B: k = {1'b1, 6'd47};  9'h04C: k = {1'b1, 6'd48};
      9'h052: k = {1'b1, 6'd50};  9'h041: k = {1'b1, 6'd51};
      9'h049: k = {1'b1, 6'd53};  9'h04A: k = {1'b1, 6'd55};
      9'h00E: k = {1'b1, 6'd56};  9'h05D: k = {1'b1, 6'd57};
      9'h005: k = {1'b1, 6'd58};  9'h006: k = {1'b1, 6'd59};
      9'h004: k = {1'b1, 6'd60};  9'h00C: k = {1'b1, 6'd62};
      default: k = '0;
    endcase
    return k;
  endfunction

  assign km = key_map({ext, byte_q});

  // Decoder: prefixes set flags, E1 swallows the rest of the Pause sequence
  always_ff @(posedge mck) begin
    if (!rin_n) begin
      kbmat   <= '0;
      key_evt <= 1'b0;
      ext     <= 1'b0;
      rel     <= 1'b0;
      skip    <= '0;
    end else begin
      key_evt <= 1'b0;
      if (kb_err) begin
        ext  <= 1'b0;
        rel  <= 1'b0;
        skip <= '0;
`ifdef KBD_ERR_CLEAR_EN
        kbmat   <= '0;
        key_evt <= |kbmat;
`endif
      end else if (byte_vld) begin
        if (skip != 3'd0)           skip <= skip - 3'd1;
        else if (byte_q == 8'hE0)   ext  <= 1'b1;
        else if (byte_q == 8'hF0)   rel  <= 1'b1;
        else if (byte_q == 8'hE1)   skip <= 3'd7;
        else begin
          ext <= 1'b0;
          rel <= 1'b0;
          if (km[6]) begin
            kbmat[km[5:0]] <= ~rel;
            key_evt        <= (kbmat[km[5:0]] == rel);
          end
        end
      end
    end
  end
endmodule
